// File: rtl/ws2812_frame_sched_pkg.sv
// ws2812_pkg: shared states, RAM lane encodings and default guard length for the WS2812 write scheduler.
package ws2812_pkg;
    typedef enum logic [2:0] {IDLE, LOAD, LINK, FULL, TERM, HOLD} state_t;
    localparam logic [3:0] LANE_LINK = 4'b1000;
    localparam logic [3:0] LANE_G = 4'b0100;
    localparam logic [3:0] LANE_R = 4'b0010;
    localparam logic [3:0] LANE_B = 4'b0001;
    localparam logic [19:0] FRAME_CYC_DEF = 20'd400000;
    function automatic logic [3:0] lane(input logic [1:0] sub);
        return sub == 2'd0 ? LANE_G : sub == 2'd1 ? LANE_R : LANE_B;
    endfunction
endpackage

// File: rtl/ws2812_frame_sched_if.sv
// ws2812_frame_sched_if: host byte stream plus RAM write port and commit pulse of the frame scheduler.
interface ws2812_frame_sched_if;
    logic       sof_in;
    logic       eof_in;
    logic       byte_vld_in;
    logic [7:0] byte_data_in;
    logic       byte_rdy_out;
    logic       err_out;
    logic [5:0] wr_addr_out;
    logic [3:0] byte_en_out;
    logic [7:0] byte_data_out;
    logic       layer_en_out;
    logic       frame_rdy_out;
    modport master (
        output sof_in, eof_in, byte_vld_in, byte_data_in,
        input  byte_rdy_out, err_out, wr_addr_out, byte_en_out, byte_data_out, layer_en_out, frame_rdy_out
    );
    modport slave (
        input  sof_in, eof_in, byte_vld_in, byte_data_in,
        output byte_rdy_out, err_out, wr_addr_out, byte_en_out, byte_data_out, layer_en_out, frame_rdy_out
    );
endinterface

// File: rtl/ws2812_guard_tmr.sv
// ws2812_guard_tmr: loadable 20-bit down-counter that reports expiry once it reaches zero.
module ws2812_guard_tmr (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        load,
    input  logic [19:0] load_val,
    output logic        expired
);
    logic [19:0] cnt;
    always_ff @(posedge clk_in or negedge rst_n_in)
        if (!rst_n_in) cnt <= '0;
        else cnt <= load ? load_val : (cnt != '0 ? cnt - 20'd1 : cnt);
    assign expired = cnt == '0;
endmodule

// File: rtl/ws2812_frame_sched.sv
// ws2812_frame_sched: writes host G/R/B bytes plus link bytes into the pixel RAM, commits frames, guards in-flight frames.
// Define WS2812_SCHED_AUTO_COMMIT_EN to commit right after the last pixel's link instead of waiting for eof_in.
module ws2812_frame_sched
    import ws2812_pkg::*;
#(
    parameter int          LED_NUM   = 64,
    parameter logic [19:0] FRAME_CYC = FRAME_CYC_DEF
) (
    input logic clk_in,
    input logic rst_n_in,
    ws2812_frame_sched_if.slave bus
);
`ifdef WS2812_SCHED_AUTO_COMMIT_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif
    state_t     state_q, state_d;
    logic [5:0] pix_q, pix_d, addr_d;
    logic [1:0] sub_q, sub_d;
    logic       cmt_q, cmt_d, pend_q, pend_d, err_q, err_d, rdy_q, rdy_d;
    logic [3:0] en_d;
    logic [7:0] data_d;
    logic       frdy_d, tmr_load, tmr_exp, sof_act, acc, last;

    ws2812_guard_tmr u_tmr (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .load     (tmr_load),
        .load_val (FRAME_CYC),
        .expired  (tmr_exp)
    );

    assign acc  = bus.byte_vld_in & rdy_q;
    assign last = pix_q == 6'(LED_NUM - 1);

    always_comb begin
        state_d  = state_q;
        pix_d    = pix_q;
        sub_d    = sub_q;
        cmt_d    = 1'b0;
        pend_d   = pend_q;
        addr_d   = pix_q;
        en_d     = 4'b0000;
        data_d   = bus.byte_data_in;
        frdy_d   = 1'b0;
        tmr_load = 1'b0;
        sof_act  = 1'b0;
        case (state_q)
            IDLE, LOAD: begin
                if (bus.sof_in) begin
                    sof_act = 1'b1;
                    state_d = LOAD;
                    pix_d   = '0;
                    sub_d   = acc ? 2'd1 : 2'd0;
                    addr_d  = '0;
                    en_d    = acc ? LANE_G : 4'b0000;
                end else if (state_q == LOAD && bus.eof_in && !AUTO) begin
                    state_d = pix_q == '0 ? IDLE : TERM;
                end else if (state_q == LOAD && acc) begin
                    en_d    = lane(sub_q);
                    sub_d   = sub_q + 2'd1;
                    state_d = sub_q == 2'd2 ? LINK : LOAD;
                end
            end
            LINK: begin
                en_d   = LANE_LINK;
                data_d = last ? 8'h00 : {2'b00, pix_q + 6'd1};
                pix_d  = pix_q + 6'd1;
                sub_d  = '0;
                if (bus.sof_in) begin
                    sof_act = 1'b1;
                    state_d = LOAD;
                    pix_d   = '0;
                end else if (!last) begin
                    state_d = LOAD;
                end else begin
                    state_d = AUTO ? HOLD : FULL;
                    cmt_d   = AUTO;
                end
            end
            FULL: begin
                if (bus.sof_in) begin
                    sof_act = 1'b1;
                    state_d = LOAD;
                    pix_d   = '0;
                    sub_d   = '0;
                end else if (bus.eof_in) begin
                    state_d = HOLD;
                    cmt_d   = 1'b1;
                end
            end
            TERM: begin
                addr_d  = pix_q - 6'd1;
                en_d    = LANE_LINK;
                data_d  = 8'h00;
                sof_act = bus.sof_in;
                state_d = bus.sof_in ? LOAD : HOLD;
                cmt_d   = !bus.sof_in;
                pix_d   = bus.sof_in ? 6'd0 : pix_q;
                sub_d   = '0;
            end
            HOLD: begin
                pend_d = pend_q | bus.sof_in;
                // The commit cycle loads the timer, so expiry is only judged afterwards.
                if (cmt_q) begin
                    frdy_d   = 1'b1;
                    tmr_load = 1'b1;
                end else if (tmr_exp) begin
                    state_d = (pend_q | bus.sof_in) ? LOAD : IDLE;
                    pend_d  = 1'b0;
                    pix_d   = '0;
                    sub_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
        rdy_d = state_d == IDLE || state_d == LOAD;
        err_d = (err_q & ~sof_act) | (bus.byte_vld_in & ~rdy_q & (state_q != IDLE));
    end

    always_ff @(posedge clk_in or negedge rst_n_in)
        if (!rst_n_in) begin
            state_q           <= IDLE;
            pix_q             <= '0;
            sub_q             <= '0;
            cmt_q             <= 1'b0;
            pend_q            <= 1'b0;
            err_q             <= 1'b0;
            rdy_q             <= 1'b1;
            bus.wr_addr_out   <= '0;
            bus.byte_en_out   <= '0;
            bus.byte_data_out <= '0;
            bus.layer_en_out  <= 1'b0;
            bus.frame_rdy_out <= 1'b0;
        end else begin
            state_q           <= state_d;
            pix_q             <= pix_d;
            sub_q             <= sub_d;
            cmt_q             <= cmt_d;
            pend_q            <= pend_d;
            err_q             <= err_d;
            rdy_q             <= rdy_d;
            bus.wr_addr_out   <= addr_d;
            bus.byte_en_out   <= en_d;
            bus.byte_data_out <= data_d;
            bus.layer_en_out  <= |en_d;
            bus.frame_rdy_out <= frdy_d;
        end

    assign bus.byte_rdy_out = rdy_q;
    assign bus.err_out      = err_q;
endmodule
